// File: rtl/counter.sv
// counter: parameterizable up/down counter with enable, synchronous clear,
// parallel load (clamped to MAX_VALUE), combinational terminal count and a
// registered wrap pulse. Arithmetic is modulo MAX_VALUE+1.
//
// Build option COUNTER_SATURATE_EN: when defined, counting past a limit holds
// at that limit instead of wrapping; o_wrap then pulses on every enabled step
// attempted at the limit.
//
// Reset is synchronous and asserted when resetn=1 (legacy port name).

module counter #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_count,
    output logic             o_tc,
    output logic             o_wrap
);

    logic [WIDTH-1:0] count_next;
    logic             wrap_next;
    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (o_count == MAX_VALUE);
    assign at_zero      = (o_count == '0);
    assign load_clamped = (i_load_value > MAX_VALUE) ? MAX_VALUE : i_load_value;

    // Terminal count follows the live direction input, not a registered copy.
    assign o_tc = i_dir ? at_zero : at_max;

    // Next-state selection in priority order: clear, load, count, hold.
    always_comb begin
        count_next = o_count;
        wrap_next  = 1'b0;
        if (i_clear) begin
            count_next = '0;
        end else if (i_load) begin
            count_next = load_clamped;
        end else if (i_enable) begin
            if (!i_dir) begin
                if (at_max) begin
`ifdef COUNTER_SATURATE_EN
                    count_next = o_count;
`else
                    count_next = '0;
`endif
                    wrap_next  = 1'b1;
                end else begin
                    count_next = o_count + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
`ifdef COUNTER_SATURATE_EN
                    count_next = o_count;
`else
                    count_next = MAX_VALUE;
`endif
                    wrap_next  = 1'b1;
                end else begin
                    count_next = o_count - WIDTH'(1);
                end
            end
        end
    end

    // Count and wrap registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (resetn) begin
            o_count <= '0;
            o_wrap  <= 1'b0;
        end else begin
            o_count <= count_next;
            o_wrap  <= wrap_next;
        end
    end

endmodule

// File: tb/tb_counter.sv
// tb_counter: scoreboard bench for counter. Stimulus steps are applied on the
// falling edge and push the hand-computed expected post-edge state into a
// queue; a monitor pops one entry after each rising edge and compares.
// Two instances: default 8-bit range, and MAX_VALUE=9 sharing the inputs.

module tb_counter;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_load = 1'b0;
    logic [7:0] i_load_value = 8'h00;
    logic       i_dir = 1'b0;
    logic [7:0] count8, count9;
    logic       tc8, tc9, wrap8, wrap9;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         sel9;
        logic [7:0] cnt;
        logic       wrap;
        logic       tc;
        string      name;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    counter u_dut8 (
        .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_clear(i_clear),
        .i_load(i_load), .i_load_value(i_load_value), .i_dir(i_dir),
        .o_count(count8), .o_tc(tc8), .o_wrap(wrap8)
    );

    counter #(.WIDTH(8), .MAX_VALUE(8'd9)) u_dut9 (
        .clk(clk), .resetn(resetn), .i_enable(i_enable), .i_clear(i_clear),
        .i_load(i_load), .i_load_value(i_load_value), .i_dir(i_dir),
        .o_count(count9), .o_tc(tc9), .o_wrap(wrap9)
    );

    // Drive one edge worth of inputs and queue the expected result of that edge.
    task automatic step(input bit rst, input bit en, input bit clr, input bit ld,
                        input logic [7:0] val, input bit dir, input bit sel9,
                        input logic [7:0] ec, input logic ew, input string nm);
        exp_t e;
        @(negedge clk);
        resetn       = rst;
        i_enable     = en;
        i_clear      = clr;
        i_load       = ld;
        i_load_value = val;
        i_dir        = dir;
        e.sel9 = sel9;
        e.cnt  = ec;
        e.wrap = ew;
        e.tc   = dir ? (ec == 8'd0) : (ec == (sel9 ? 8'd9 : 8'd255));
        e.name = nm;
        q.push_back(e);
    endtask

    // Monitor: compare the selected instance after every rising edge.
    initial begin
        exp_t       e;
        logic [7:0] c;
        logic       w, t;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                c = e.sel9 ? count9 : count8;
                w = e.sel9 ? wrap9  : wrap8;
                t = e.sel9 ? tc9    : tc8;
                n_checks += 3;
                if (c !== e.cnt) begin
                    n_fail++;
                    $display("FAIL %s count: got %0d expected %0d at %0t", e.name, c, e.cnt, $time);
                end
                if (w !== e.wrap) begin
                    n_fail++;
                    $display("FAIL %s wrap: got %b expected %b at %0t", e.name, w, e.wrap, $time);
                end
                if (t !== e.tc) begin
                    n_fail++;
                    $display("FAIL %s tc: got %b expected %b at %0t", e.name, t, e.tc, $time);
                end
            end
        end
    end

    initial begin
        logic [7:0] ec;
        bit         ew;
        int         budget;

        // Reset held with enable high, then first increments.
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 8'h00, 0, 0, 8'd0, 0, "reset_hold");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'd1, 0, "first_inc");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'd2, 0, "second_inc");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'd3, 0, "third_inc");

        // Enable gating.
        step(1, 0, 0, 0, 8'h00, 0, 0, 8'd0, 0, "reset2");
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 8'h00, 0, 0, 8'd0, 0, "idle_zero");
        for (int i = 1; i <= 500; i++) begin
`ifdef COUNTER_SATURATE_EN
            ec = (i > 255) ? 8'd255 : 8'(i);
            ew = (i > 255);
`else
            ec = 8'(i % 256);
            ew = (i == 256);
`endif
            step(0, 1, 0, 0, 8'h00, 0, 0, ec, ew, "run500");
        end
`ifdef COUNTER_SATURATE_EN
        ec = 8'd255;
`else
        ec = 8'hF4;
`endif
        for (int i = 0; i < 100; i++) step(0, 0, 0, 0, 8'h00, 0, 0, ec, 0, "freeze");

        // Wrap up.
        step(0, 0, 0, 1, 8'hFE, 0, 0, 8'hFE, 0, "load_fe");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, "up_to_ff");
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 1, "up_limit");
        step(0, 0, 0, 0, 8'h00, 0, 0, 8'hFF, 0, "wrap_clears");
`else
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, "up_wrap");
        step(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, "wrap_clears");
`endif

        // Wrap down.
        step(0, 0, 0, 1, 8'h01, 1, 0, 8'h01, 0, "load_01_down");
        step(0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 0, "down_to_0");
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00, 1, 0, 8'h00, 1, "down_limit");
`else
        step(0, 1, 0, 0, 8'h00, 1, 0, 8'hFF, 1, "down_wrap");
`endif
        step(0, 0, 0, 0, 8'h00, 1, 0, (`ifdef COUNTER_SATURATE_EN 8'h00 `else 8'hFF `endif), 0, "down_hold");

        // Priority.
        step(0, 1, 1, 1, 8'h55, 0, 0, 8'h00, 0, "clr_wins");
        step(0, 1, 0, 1, 8'h55, 0, 0, 8'h55, 0, "load_wins");
        step(0, 1, 0, 0, 8'h00, 1, 0, 8'h54, 0, "dir_down");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h55, 0, "dir_up");
        step(1, 1, 1, 1, 8'h77, 1, 0, 8'h00, 0, "reset_wins");

        // Saturation vs wrap from 0xFD.
        step(0, 0, 0, 1, 8'hFD, 0, 0, 8'hFD, 0, "load_fd");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFE, 0, "fd_s1");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 0, "fd_s2");
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 1, "fd_s3");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 1, "fd_s4");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'hFF, 1, "fd_s5");
`else
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h00, 1, "fd_s3");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h01, 0, "fd_s4");
        step(0, 1, 0, 0, 8'h00, 0, 0, 8'h02, 0, "fd_s5");
`endif

        // Non-power-of-two range on the MAX_VALUE=9 instance.
        step(1, 0, 0, 0, 8'h00, 0, 1, 8'd0, 0, "m9_reset");
        for (int i = 1; i <= 9; i++) step(0, 1, 0, 0, 8'h00, 0, 1, 8'(i), 0, "m9_up");
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00, 0, 1, 8'd9, 1, "m9_limit");
`else
        step(0, 1, 0, 0, 8'h00, 0, 1, 8'd0, 1, "m9_wrap");
`endif
        step(0, 0, 0, 1, 8'd12, 0, 1, 8'd9, 0, "m9_load_clamp");
        step(0, 0, 0, 1, 8'd200, 1, 1, 8'd9, 0, "m9_load_big");
        step(0, 0, 1, 0, 8'h00, 1, 1, 8'd0, 0, "m9_clear");
`ifdef COUNTER_SATURATE_EN
        step(0, 1, 0, 0, 8'h00, 1, 1, 8'd0, 1, "m9_down_limit");
`else
        step(0, 1, 0, 0, 8'h00, 1, 1, 8'd9, 1, "m9_down_wrap");
`endif
        step(0, 0, 0, 0, 8'h00, 0, 1, (`ifdef COUNTER_SATURATE_EN 8'd0 `else 8'd9 `endif), 0, "m9_hold");

        // Drain the scoreboard within a bounded number of cycles.
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        #2;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
